// File: rtl/bldc_pkg.sv
// Shared phase codes, gate map and parameter defaults for the BLDC commutation/PWM drive stage.
package bldc_pkg;

    localparam int unsigned T_WIDTH_DEF  = 32;
    localparam int unsigned PWM_BITS_DEF = 8;
    localparam int unsigned DEADTIME_DEF = 4;

    localparam logic [2:0] PH_AB = 3'b001;
    localparam logic [2:0] PH_AC = 3'b011;
    localparam logic [2:0] PH_BC = 3'b010;
    localparam logic [2:0] PH_BA = 3'b110;
    localparam logic [2:0] PH_CA = 3'b100;
    localparam logic [2:0] PH_CB = 3'b101;

    typedef enum logic [2:0] {
        PhAB = PH_AB,
        PhAC = PH_AC,
        PhBC = PH_BC,
        PhBA = PH_BA,
        PhCA = PH_CA,
        PhCB = PH_CB
    } phase_e;

    // One-hot leg selects, bit order {C,B,A}.
    typedef struct packed {
        logic [2:0] hi_sel;
        logic [2:0] lo_sel;
    } gate_sel_t;

    function automatic logic phase_legal(input logic [2:0] code);
        return (code != 3'b000) && (code != 3'b111);
    endfunction

    function automatic phase_e next_phase(input phase_e ph);
        case (ph)
            PhAB:    return PhAC;
            PhAC:    return PhBC;
            PhBC:    return PhBA;
            PhBA:    return PhCA;
            PhCA:    return PhCB;
            PhCB:    return PhAB;
            default: return PhAB;
        endcase
    endfunction

    function automatic gate_sel_t gate_map(input phase_e ph);
        gate_sel_t sel;
        case (ph)
            PhAB:    sel = '{hi_sel: 3'b001, lo_sel: 3'b010};
            PhAC:    sel = '{hi_sel: 3'b001, lo_sel: 3'b100};
            PhBC:    sel = '{hi_sel: 3'b010, lo_sel: 3'b100};
            PhBA:    sel = '{hi_sel: 3'b010, lo_sel: 3'b001};
            PhCA:    sel = '{hi_sel: 3'b100, lo_sel: 3'b001};
            PhCB:    sel = '{hi_sel: 3'b100, lo_sel: 3'b010};
            default: sel = '{hi_sel: 3'b000, lo_sel: 3'b000};
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/bldc_pwm_gen.sv
// Edge-aligned PWM: free-running counter, duty latched once per period start, pwm_on compare.
module bldc_pwm_gen #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_on
);

    localparam logic [PWM_BITS-1:0] CntOne = PWM_BITS'(1);

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] duty_lat_q;
    logic [PWM_BITS-1:0] duty_eff;
    logic                period_start;

    // pwm_cnt is 0 both on wrap and on the first enabled cycle, so one condition covers both loads.
    always_comb begin
        period_start = en && (pwm_cnt_q == '0);
        duty_eff     = period_start ? duty : duty_lat_q;
        pwm_on       = en && (pwm_cnt_q < duty_eff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q  <= '0;
            duty_lat_q <= '0;
        end else begin
            pwm_cnt_q <= en ? (pwm_cnt_q + CntOne) : '0;
            if (period_start) begin
                duty_lat_q <= duty;
            end
        end
    end

endmodule

// File: rtl/bldc_commutation_pwm.sv
// 6-step BLDC commutation with PWM high-side drive and registered gate outputs.
// Optional dead time on every phase advance is enabled by defining BLDC_DEADTIME_EN.
module bldc_commutation_pwm
    import bldc_pkg::*;
#(
    parameter int unsigned T_WIDTH  = T_WIDTH_DEF,
    parameter int unsigned PWM_BITS = PWM_BITS_DEF,
    parameter int unsigned DEADTIME = DEADTIME_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [T_WIDTH-1:0]  T_value,
    output logic [2:0]          phase_state,
    output logic [2:0]          gate_hi,
    output logic [2:0]          gate_lo,
    output logic                step_tick
);

    localparam logic [T_WIDTH-1:0] TOne = T_WIDTH'(1);

    logic               en_q;
    logic               rise;
    logic [T_WIDTH-1:0] t_lat_q, t_lat_d;
    logic [T_WIDTH-1:0] t_eff;
    logic [T_WIDTH-1:0] step_cnt_q, step_cnt_d;
    logic               boundary;
    phase_e             phase_q, phase_d;
    logic               step_tick_q;
    logic               pwm_on;
    logic               dead;
    gate_sel_t          sel;
    logic [2:0]         gate_hi_q, gate_hi_d;
    logic [2:0]         gate_lo_q, gate_lo_d;

    bldc_pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .duty   (duty),
        .pwm_on (pwm_on)
    );

    // On the enable edge the fresh T_value is used immediately, before t_lat_q has it.
    always_comb begin
        rise       = en & ~en_q;
        t_eff      = rise ? T_value : t_lat_q;
        boundary   = en && (t_eff != '0) && (step_cnt_q == t_eff - TOne);
        t_lat_d    = t_lat_q;
        step_cnt_d = step_cnt_q;
        if (!en) begin
            step_cnt_d = '0;
        end else begin
            if (rise) begin
                t_lat_d = T_value;
            end
            if (boundary) begin
                step_cnt_d = '0;
                t_lat_d    = T_value;
            end else if (t_eff != '0) begin
                step_cnt_d = step_cnt_q + TOne;
            end
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (boundary) begin
            phase_d = next_phase(phase_q);
        end else if (!phase_legal(phase_q)) begin
            phase_d = PhAB;
        end
    end

`ifdef BLDC_DEADTIME_EN
    localparam int unsigned DtW = (DEADTIME > 1) ? $clog2(DEADTIME + 1) : 1;

    logic [DtW-1:0] dt_cnt_q;

    // Reloads on every boundary, so a step inside dead time restarts it.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            dt_cnt_q <= '0;
        end else if (boundary) begin
            dt_cnt_q <= DtW'(DEADTIME);
        end else if (dt_cnt_q != '0) begin
            dt_cnt_q <= dt_cnt_q - DtW'(1);
        end
    end

    assign dead = (dt_cnt_q != '0);
`else
    logic unused_deadtime;
    assign unused_deadtime = (DEADTIME == 0);
    assign dead            = 1'b0;
`endif

    always_comb begin
        sel       = gate_map(phase_q);
        gate_hi_d = '0;
        gate_lo_d = '0;
        if (en && !dead) begin
            gate_hi_d = sel.hi_sel & {3{pwm_on}};
            gate_lo_d = sel.lo_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q        <= 1'b0;
            t_lat_q     <= '0;
            step_cnt_q  <= '0;
            phase_q     <= PhAB;
            step_tick_q <= 1'b0;
            gate_hi_q   <= '0;
            gate_lo_q   <= '0;
        end else begin
            en_q        <= en;
            t_lat_q     <= t_lat_d;
            step_cnt_q  <= step_cnt_d;
            phase_q     <= phase_d;
            step_tick_q <= boundary;
            gate_hi_q   <= gate_hi_d;
            gate_lo_q   <= gate_lo_d;
        end
    end

    assign phase_state = phase_q;
    assign step_tick   = step_tick_q;
    assign gate_hi     = gate_hi_q;
    assign gate_lo     = gate_lo_q;

endmodule

// File: tb/tb_bldc_commutation_pwm.sv
// Randomised scoreboard bench for bldc_commutation_pwm against a per-cycle behavioural model.
module tb_bldc_commutation_pwm;

`ifdef BLDC_DEADTIME_EN
    localparam int unsigned DT = 4;
`else
    localparam int unsigned DT = 0;
`endif
    localparam int unsigned PERIOD = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  duty;
    logic [31:0] T_value;
    logic [2:0]  phase_state;
    logic [2:0]  gate_hi;
    logic [2:0]  gate_lo;
    logic        step_tick;

    bldc_commutation_pwm #(
        .T_WIDTH  (32),
        .PWM_BITS (8),
        .DEADTIME (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .duty        (duty),
        .T_value     (T_value),
        .phase_state (phase_state),
        .gate_hi     (gate_hi),
        .gate_lo     (gate_lo),
        .step_tick   (step_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] phase;
        logic [2:0] hi;
        logic [2:0] lo;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;
    int   cycle  = 0;
    bit   started = 1'b0;

    // Commutation table by step index: phase code, high-side leg, low-side leg (A=0, B=1, C=2).
    int codes[6]  = '{1, 3, 2, 6, 4, 5};
    int hi_leg[6] = '{0, 0, 1, 1, 2, 2};
    int lo_leg[6] = '{1, 2, 2, 0, 0, 1};

    int unsigned m_en_prev, m_step_len, m_elapsed, m_idx, m_pos, m_pduty, m_dead;

    task automatic model_step(input bit r, input bit e, input logic [7:0] d, input int unsigned t);
        exp_t x;
        bit   on;
        bit   tick;
        x = '0;
        if (r) begin
            m_en_prev = 0; m_step_len = 0; m_elapsed = 0; m_idx = 0;
            m_pos = 0; m_pduty = 0; m_dead = 0;
        end else if (e) begin
            tick = 1'b0;
            if (m_en_prev == 0) begin
                m_step_len = t;
                m_elapsed  = 0;
            end
            if (m_pos == 0) m_pduty = d;
            on = (m_pos < m_pduty);
            if (m_dead == 0) begin
                x.hi[hi_leg[m_idx]] = on;
                x.lo[lo_leg[m_idx]] = 1'b1;
            end
            m_pos = (m_pos + 1) % PERIOD;
            if (m_step_len != 0) begin
                m_elapsed++;
                if (m_elapsed == m_step_len) begin
                    m_elapsed  = 0;
                    m_idx      = (m_idx + 1) % 6;
                    m_step_len = t;
                    tick       = 1'b1;
                end
            end
            if (tick) m_dead = DT;
            else if (m_dead > 0) m_dead--;
            x.tick = tick;
        end else begin
            m_elapsed = 0; m_pos = 0; m_dead = 0;
        end
        if (!r) m_en_prev = e;
        x.phase = 3'(codes[m_idx]);
        exp_q.push_back(x);
    endtask

    task automatic cyc(input bit r, input bit e, input logic [7:0] d, input int unsigned t);
        @(negedge clk);
        rst     = r;
        en      = e;
        duty    = d;
        T_value = t;
        model_step(r, e, d, t);
    endtask

    // Monitor: every clock the DUT presents a new output set; pop and compare.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                started = 1'b1;
                tests++;
                if (phase_state !== x.phase || gate_hi !== x.hi || gate_lo !== x.lo
                    || step_tick !== x.tick) begin
                    failed++;
                    $display("FAIL outputs cycle %0d: got phase=%b hi=%b lo=%b tick=%b, want phase=%b hi=%b lo=%b tick=%b",
                             cycle, phase_state, gate_hi, gate_lo, step_tick,
                             x.phase, x.hi, x.lo, x.tick);
                end
            end
            if (started) begin
                tests++;
                if ((gate_hi & gate_lo) !== 3'b000) begin
                    failed++;
                    $display("FAIL overlap cycle %0d: got hi=%b lo=%b, want no common leg",
                             cycle, gate_hi, gate_lo);
                end
            end
        end
    end

    function automatic int unsigned pick_t();
        case ($urandom_range(0, 4))
            0:       return 0;
            1:       return 1;
            2:       return 2;
            3:       return 3;
            default: return $urandom_range(4, 30);
        endcase
    endfunction

    initial begin
        logic [7:0]  dv;
        int          n;
        int unsigned tv;
        bit          ev;
        rst = 1'b1; en = 1'b0; duty = '0; T_value = '0;

        repeat (2) cyc(1'b1, 1'b0, 8'd0, 0);
        repeat (100) cyc(1'b0, 1'b0, 8'($urandom), $urandom_range(1, 20));
        repeat (700) cyc(1'b0, 1'b1, 8'd128, 10);

        // Duty changes at arbitrary points within a PWM period.
        for (int seg = 0; seg < 6; seg++) begin
            case (seg % 3)
                0:       dv = 8'd0;
                1:       dv = 8'd255;
                default: dv = 8'($urandom);
            endcase
            n = $urandom_range(50, 400);
            repeat (n) cyc(1'b0, 1'b1, dv, 10);
        end

        // Step length change mid-step, then a zero step length.
        repeat (15) cyc(1'b0, 1'b1, 8'd100, 10);
        repeat (60) cyc(1'b0, 1'b1, 8'd100, 20);
        repeat (150) cyc(1'b0, 1'b1, 8'd100, 0);

        // Enable toggling with short segments.
        for (int seg = 0; seg < 40; seg++) begin
            ev = (seg % 2 == 1);
            n  = $urandom_range(1, 60);
            tv = $urandom_range(0, 15);
            repeat (n) cyc(1'b0, ev, 8'($urandom), tv);
        end

        // Fully random per-cycle inputs with occasional reset.
        repeat (2000) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 19) != 0, 8'($urandom), pick_t());
        end

        @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
